// File: rtl/exam_pkg.sv
// rtl/exam_pkg.sv - shared types, constants and helpers for the DE2 exam wrappers
// Contents: state_t FSM encoding, clog2() width helper, st_led one-hot codes.
package exam_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_PRESS   = 3'd0,
        ST_CAPTURE      = 3'd1,
        ST_WAIT_RELEASE = 3'd2,
        ST_EXEC         = 3'd3,
        ST_FINISHED     = 3'd4
    } state_t;

    // st_led bit order is {DONE, EXEC, CAPTURING, WAIT}
    localparam logic [3:0] LED_WAIT      = 4'b0001;
    localparam logic [3:0] LED_CAPTURING = 4'b0010;
    localparam logic [3:0] LED_EXEC      = 4'b0100;
    localparam logic [3:0] LED_DONE      = 4'b1000;

    // Ceiling log2; clog2(1) is 0, callers clamp where a zero-width bus would result
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/key_edge_sync.sv
// rtl/key_edge_sync.sv - 2-flop synchroniser with registered falling-edge pulse for one pushbutton
// Ports: clk_i, rst_ni (async active-low), key_n_i (raw active-low key),
//        level_o (synchronised key level), pulse_o (1-cycle press pulse).
module key_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_n_i,
    output logic level_o,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic pulse_q;

    // Flops reset to the "pressed" level so a key held through reset produces
    // no pulse until it has been released and pressed again.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pulse_q <= prev_q & ~sync2_q;
        end
    end

    assign level_o = sync2_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/operand_entry_seq.sv
// rtl/operand_entry_seq.sv - operand-entry sequencer between the DE2 switch debouncer and an exam datapath
// Ports: CLOCK_50, rst (async active-low); sw_data/sw_arm switches; key_n/key_sel_n raw keys;
//        ops (captured operands), start/done handshake, res (results), disp/sel result display,
//        op_idx (next operand slot), st_led (one-hot {DONE, EXEC, CAPTURING, WAIT}).
module operand_entry_seq
    import exam_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NUM_OPS = 4,
    parameter int NUM_RES = 2,
    localparam int SEL_W  = (clog2(NUM_RES) < 1) ? 1 : clog2(NUM_RES),
    localparam int IDX_W  = clog2(NUM_OPS + 1)
) (
    input  logic                       CLOCK_50,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           sw_data,
    input  logic                       sw_arm,
    input  logic                       key_n,
    input  logic                       key_sel_n,
    output logic [NUM_OPS*WIDTH-1:0]   ops,
    output logic                       start,
    input  logic                       done,
    input  logic [NUM_RES*WIDTH-1:0]   res,
    output logic [WIDTH-1:0]           disp,
    output logic [SEL_W-1:0]           sel,
    output logic [IDX_W-1:0]           op_idx,
    output logic [3:0]                 st_led
);

    localparam logic [IDX_W-1:0] OPS_FULL = IDX_W'(NUM_OPS);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_RES - 1);

    logic next_level;
    logic next_pulse;
    logic sel_pulse;

    state_t                     state_q;
    logic [NUM_OPS*WIDTH-1:0]   ops_q;
    logic [IDX_W-1:0]           op_idx_q;
    logic                       start_q;
    logic [3:0]                 st_led_q;
    logic [SEL_W-1:0]           sel_q;
    logic [WIDTH-1:0]           disp_q;

    key_edge_sync u_next_key (
        .clk_i   (CLOCK_50),
        .rst_ni  (rst),
        .key_n_i (key_n),
        .level_o (next_level),
        .pulse_o (next_pulse)
    );

    key_edge_sync u_sel_key (
        .clk_i   (CLOCK_50),
        .rst_ni  (rst),
        .key_n_i (key_sel_n),
        .level_o (),
        .pulse_o (sel_pulse)
    );

    // The operand write and index increment are issued on the edge that enters
    // CAPTURE, so the operand lands one edge after the press pulse; CAPTURE then
    // hands over to WAIT_RELEASE.
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_WAIT_PRESS;
            ops_q    <= '0;
            op_idx_q <= '0;
            start_q  <= 1'b0;
            st_led_q <= LED_WAIT;
        end else begin
            case (state_q)
                ST_WAIT_PRESS: begin
                    if (next_pulse) begin
                        if (op_idx_q == OPS_FULL) begin
                            state_q  <= ST_EXEC;
                            start_q  <= 1'b1;
                            st_led_q <= LED_EXEC;
                        end else if (sw_arm) begin
                            ops_q[int'(op_idx_q)*WIDTH +: WIDTH] <= sw_data;
                            op_idx_q <= op_idx_q + IDX_W'(1);
                            state_q  <= ST_CAPTURE;
                            st_led_q <= LED_CAPTURING;
                        end
                    end
                end
                ST_CAPTURE: begin
                    state_q  <= ST_WAIT_RELEASE;
                    st_led_q <= LED_CAPTURING;
                end
                ST_WAIT_RELEASE: begin
                    if (next_level) begin
                        state_q  <= ST_WAIT_PRESS;
                        st_led_q <= LED_WAIT;
                    end
                end
                ST_EXEC: begin
                    if (done) begin
                        state_q  <= ST_FINISHED;
                        st_led_q <= LED_DONE;
                    end
                end
                ST_FINISHED: begin
                    // Restart: operands are kept so only the ones re-entered change
                    if (next_pulse) begin
                        start_q  <= 1'b0;
                        op_idx_q <= '0;
                        state_q  <= ST_WAIT_RELEASE;
                        st_led_q <= LED_CAPTURING;
                    end
                end
                default: begin
                    state_q  <= ST_WAIT_PRESS;
                    start_q  <= 1'b0;
                    st_led_q <= LED_WAIT;
                end
            endcase
        end
    end

    // Result selection runs independently of the FSM
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            sel_q  <= '0;
            disp_q <= '0;
        end else begin
            if (sel_pulse) begin
                sel_q <= (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
            end
            disp_q <= res[int'(sel_q)*WIDTH +: WIDTH];
        end
    end

    assign ops    = ops_q;
    assign start  = start_q;
    assign op_idx = op_idx_q;
    assign st_led = st_led_q;
    assign sel    = sel_q;
    assign disp   = disp_q;

endmodule
